// File: rtl/vector_divide4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vector_divide4_pkg
//  Description : Shared lane geometry and controller state encodings for the
//                vector arithmetic blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package vector_divide4_pkg;

    // Default vector geometry: number of lanes and width of each lane
    localparam int c_SIZE_ARRAY = 4;
    localparam int c_SIZE_INT   = 32;

    // Controller state encodings
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/vector_divide4_div_lane_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_lane_step
//  Description : One restoring-division iteration for a single lane: shift the
//                partial remainder left, bring in the next dividend bit,
//                conditionally subtract the divisor and emit the quotient bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_lane_step #(
    parameter int SIZE_INT = 32
) (
    input  logic [SIZE_INT-1:0] i_rem,
    input  logic [SIZE_INT-1:0] i_divisor,
    input  logic                i_din,
    output logic [SIZE_INT-1:0] o_rem,
    output logic                o_qbit
);

    // The shifted remainder is SIZE_INT+1 bits so the compare cannot overflow.
    logic [SIZE_INT:0] w_shift;
    logic              w_ge;

    // Shift/compare/subtract for one quotient bit. The subtraction can be done
    // in SIZE_INT bits because the true difference is always below the divisor.
    always_comb begin
        w_shift = {i_rem, i_din};
        w_ge    = (w_shift >= {1'b0, i_divisor});
        o_qbit  = w_ge;
        o_rem   = w_ge ? (w_shift[SIZE_INT-1:0] - i_divisor) : w_shift[SIZE_INT-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/vector_divide4.sv
`default_nettype none
// ============================================================================
//  Module      : vector_divide4
//  Description : Multi-lane unsigned restoring divider. All lanes iterate in
//                lockstep, one quotient bit per clock, with a valid/ready
//                handshake on both sides. A zero divisor yields an all-ones
//                quotient, the dividend as remainder and a per-lane flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module vector_divide4
    import vector_divide4_pkg::*;
#(
    parameter int SIZE_ARRAY = c_SIZE_ARRAY,
    parameter int SIZE_INT   = c_SIZE_INT,
    parameter int SIZE       = SIZE_ARRAY * SIZE_INT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SIZE-1:0]       IX,
    input  logic [SIZE-1:0]       IY,
    output logic [SIZE-1:0]       quotient,
    output logic [SIZE-1:0]       remainder,
    output logic [SIZE_ARRAY-1:0] div_by_zero,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int                c_CNT_W    = (SIZE_INT > 1) ? $clog2(SIZE_INT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(SIZE_INT - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic                  w_accept;
    logic                  w_step;
    logic [c_CNT_W-1:0]    r_count;
    logic [SIZE-1:0]       r_dividend;
    logic [SIZE-1:0]       r_divisor;
    logic [SIZE-1:0]       r_quot;
    logic [SIZE-1:0]       r_rem;
    logic [SIZE_ARRAY-1:0] r_dbz;
    logic [SIZE-1:0]       w_dividend_next;
    logic [SIZE-1:0]       w_quot_next;
    logic [SIZE-1:0]       w_rem_next;
    logic [SIZE_ARRAY-1:0] w_qbit;

    // Controller state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake decode; a result handshake always lands in
    // IDLE, so the next operation can only be accepted one cycle later.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = c_ST_BUSY;
                end
            end
            c_ST_BUSY: begin
                w_step = 1'b1;
                if (r_count == '0) begin
                    w_state_next = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // Per-lane iteration logic; the dividend register shifts left so its
    // MSB always holds the next dividend bit to bring in.
    generate
        for (genvar k = 0; k < SIZE_ARRAY; k++) begin : g_lane
            div_lane_step #(
                .SIZE_INT (SIZE_INT)
            ) u_step (
                .i_rem     (r_rem[k*SIZE_INT +: SIZE_INT]),
                .i_divisor (r_divisor[k*SIZE_INT +: SIZE_INT]),
                .i_din     (r_dividend[k*SIZE_INT + SIZE_INT - 1]),
                .o_rem     (w_rem_next[k*SIZE_INT +: SIZE_INT]),
                .o_qbit    (w_qbit[k])
            );

            assign w_dividend_next[k*SIZE_INT +: SIZE_INT] =
                {r_dividend[k*SIZE_INT +: SIZE_INT-1], 1'b0};
            assign w_quot_next[k*SIZE_INT +: SIZE_INT] =
                {r_quot[k*SIZE_INT +: SIZE_INT-1], w_qbit[k]};
        end
    endgenerate

    // Operand capture on accept, one iteration per BUSY cycle; results hold
    // untouched through DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_dbz      <= '0;
        end else if (w_accept) begin
            r_count    <= c_CNT_LOAD;
            r_dividend <= IX;
            r_divisor  <= IY;
            r_quot     <= '0;
            r_rem      <= '0;
            for (int k = 0; k < SIZE_ARRAY; k++) begin
                r_dbz[k] <= (IY[k*SIZE_INT +: SIZE_INT] == '0);
            end
        end else if (w_step) begin
            r_dividend <= w_dividend_next;
            r_quot     <= w_quot_next;
            r_rem      <= w_rem_next;
            if (r_count != '0) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_vector_divide4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vector_divide4
//  Description : Self-checking bench for vector_divide4 with an arithmetic
//                reference model and a queue-based scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_divide4;

    localparam int LANES = 4;
    localparam int W     = 32;
    localparam int SIZE  = LANES * W;

    typedef struct {
        logic [SIZE-1:0]  q;
        logic [SIZE-1:0]  r;
        logic [LANES-1:0] dbz;
        int               acc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [SIZE-1:0]  IX;
    logic [SIZE-1:0]  IY;
    logic [SIZE-1:0]  quotient;
    logic [SIZE-1:0]  remainder;
    logic [LANES-1:0] div_by_zero;
    logic             out_valid;
    logic             out_ready;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    bit   seen = 0;
    bit   rand_ready = 0;

    vector_divide4 #(
        .SIZE_ARRAY (LANES),
        .SIZE_INT   (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .IX          (IX),
        .IY          (IY),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Random consumer back-pressure while enabled
    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string nm, input logic [SIZE-1:0] act, input logic [SIZE-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_timeout(input string nm);
        n_vec++;
        n_bad++;
        $display("FAIL %s: got timeout expected completion", nm);
    endtask

    // Reference: plain integer division per lane, zero divisor handled explicitly
    function automatic exp_t model(input logic [SIZE-1:0] x, input logic [SIZE-1:0] y, input int acc);
        exp_t        e;
        logic [W-1:0] a;
        logic [W-1:0] b;
        e.acc = acc;
        e.q   = '0;
        e.r   = '0;
        e.dbz = '0;
        for (int k = 0; k < LANES; k++) begin
            a = x[k*W +: W];
            b = y[k*W +: W];
            if (b == 0) begin
                e.q[k*W +: W] = {W{1'b1}};
                e.r[k*W +: W] = a;
                e.dbz[k]      = 1'b1;
            end else begin
                e.q[k*W +: W] = a / b;
                e.r[k*W +: W] = a % b;
            end
        end
        return e;
    endfunction

    task automatic rand_ops(output logic [SIZE-1:0] x, output logic [SIZE-1:0] y);
        int mode;
        for (int k = 0; k < LANES; k++) begin
            mode = int'($urandom_range(0, 7));
            if (mode == 0)      y[k*W +: W] = '0;
            else if (mode < 3)  y[k*W +: W] = W'($urandom_range(1, 15));
            else                y[k*W +: W] = W'($urandom);
            if (mode == 3)      x[k*W +: W] = W'($urandom_range(0, 20));
            else                x[k*W +: W] = W'($urandom);
        end
    endtask

    // Present one operation and hold it until accepted; reports idle wait cycles
    task automatic issue(input logic [SIZE-1:0] x, input logic [SIZE-1:0] y, output int waited);
        bit ok;
        ok     = 0;
        waited = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        IX       = x;
        IY       = y;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(x, y, cyc + 1));
                ok = 1;
            end else begin
                waited++;
            end
        end
        if (!ok) fail_timeout("accept_timeout");
        @(posedge clk); #1;
        in_valid = 1'b0;
        IX       = {4{32'($urandom)}};
        IY       = {4{32'($urandom)}};
    endtask

    task automatic drain(input string nm);
        bit done;
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0) done = 1;
        end
        if (!done) fail_timeout(nm);
    endtask

    // Monitor: results compared while out_valid is high (covers hold stability),
    // popped on the cycle the handshake completes
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            seen = 0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", SIZE'(out_valid), '0);
            end else begin
                e = sb[0];
                if (!seen) begin
                    chk("latency", SIZE'(cyc - e.acc), SIZE'(W));
                    seen = 1;
                end
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", SIZE'(div_by_zero), SIZE'(e.dbz));
                chk("in_ready_in_done", SIZE'(in_ready), '0);
                if (out_ready) begin
                    void'(sb.pop_front());
                    seen = 0;
                end
            end
        end
    end

    initial begin
        logic [SIZE-1:0] x;
        logic [SIZE-1:0] y;
        int              waited;
        int              nacc;
        int              last;
        bit              got;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        IX        = '0;
        IY        = '0;
        #12;
        chk("reset_in_ready", SIZE'(in_ready), SIZE'(1));
        chk("reset_out_valid", SIZE'(out_valid), '0);
        chk("reset_quotient", quotient, '0);
        chk("reset_remainder", remainder, '0);
        chk("reset_dbz", SIZE'(div_by_zero), '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Mixed lanes: ordinary, dividend < divisor, divide by one, power of two
        x = {32'h80000000, 32'hFFFFFFFF, 32'd3, 32'd100};
        y = {32'h00000010, 32'd1, 32'd10, 32'd7};
        issue(x, y, waited);
        chk("first_accept_wait", SIZE'(waited), '0);
        drain("drain_mixed");

        // Divide by zero on lane 2 only
        x = {32'd9, 32'd5, 32'd9, 32'd9};
        y = {32'd3, 32'd0, 32'd3, 32'd3};
        issue(x, y, waited);
        drain("drain_dbz");

        // Consumer stalls for 5 cycles in DONE
        out_ready = 1'b0;
        rand_ops(x, y);
        issue(x, y, waited);
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (out_valid) got = 1;
        end
        if (!got) fail_timeout("stall_wait_valid");
        repeat (5) @(negedge clk);
        chk("stall_out_valid", SIZE'(out_valid), SIZE'(1));
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_after_hs_valid", SIZE'(out_valid), '0);
        chk("idle_after_hs_ready", SIZE'(in_ready), SIZE'(1));
        drain("drain_stall");

        // Operands churn while BUSY/DONE and must be ignored
        out_ready = 1'b0;
        x = {32'd1000, 32'd77, 32'hDEADBEEF, 32'd12345};
        y = {32'd33, 32'd0, 32'd13, 32'd10};
        issue(x, y, waited);
        repeat (40) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            IX = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
            IY = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("drain_churn");

        // Reset in the middle of BUSY
        x = {32'd1, 32'd2, 32'd3, 32'd100};
        y = {32'd1, 32'd1, 32'd1, 32'd7};
        issue(x, y, waited);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", SIZE'(in_ready), SIZE'(1));
        chk("midrst_out_valid", SIZE'(out_valid), '0);
        chk("midrst_quotient", quotient, '0);
        chk("midrst_remainder", remainder, '0);
        chk("midrst_dbz", SIZE'(div_by_zero), '0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        x = {32'd100, 32'd100, 32'd100, 32'd100};
        y = {32'd7, 32'd7, 32'd7, 32'd7};
        issue(x, y, waited);
        chk("post_rst_accept_wait", SIZE'(waited), '0);
        drain("drain_post_rst");

        // Back-to-back with in_valid and out_ready held high
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1;
        rand_ops(x, y);
        IX = x;
        IY = y;
        nacc = 0;
        last = -1;
        for (int i = 0; i < 400 && nacc < 4; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(IX, IY, cyc + 1));
                if (last >= 0) chk("b2b_spacing", SIZE'(cyc + 1 - last), SIZE'(W + 2));
                last = cyc + 1;
                nacc++;
                @(posedge clk); #1;
                rand_ops(x, y);
                IX = x;
                IY = y;
                if (nacc == 4) in_valid = 1'b0;
            end
        end
        if (nacc < 4) fail_timeout("b2b_accepts");
        drain("drain_b2b");

        // Randomized operations with random back-pressure
        rand_ready = 1;
        for (int n = 0; n < 20; n++) begin
            rand_ops(x, y);
            issue(x, y, waited);
        end
        drain("drain_random");
        rand_ready = 0;
        @(posedge clk); #1;
        out_ready = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
